// File: rtl/score_pkg.sv
// Shared types, seven-segment constants and arithmetic helpers for the score keeper.
package score_pkg;

  typedef enum logic [1:0] {IDLE, PLAYING, DRAIN, OVER} state_t;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp is held off.
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Four-digit BCD +1 with ripple carry; holds at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != BCD_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-side interface: kill pulses and alive flag in, score and display drive out.
interface score_keeper_if #(
  parameter int MONSTERS = 12
);
  logic                alive;
  logic [MONSTERS-1:0] score_pulse;
  logic [15:0]         score_bcd;
  logic [15:0]         high_bcd;
  logic                new_high;
  logic [3:0]          an;
  logic [7:0]          seg;

  modport master (
    output alive, score_pulse,
    input  score_bcd, high_bcd, new_high, an, seg
  );

  modport slave (
    input  alive, score_pulse,
    output score_bcd, high_bcd, new_high, an, seg
  );
endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; codes 10-15 blank the digit.
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/score_keeper.sv
// Per-game BCD score with session high score and a multiplexed 4-digit display.
// Kill pulses are edge-detected, queued in a saturating counter and drained one point per cycle.
module score_keeper
  import score_pkg::*;
#(
  parameter int MONSTERS     = 12,
  parameter int REFRESH_BITS = 17,
  parameter int BLINK_BIT    = 24,
  parameter int PEND_BITS    = 8
) (
  input logic           clk_game,
  input logic           rst_n,
  score_keeper_if.slave bus
);
  localparam int CNT_W = (REFRESH_BITS > BLINK_BIT + 1) ? REFRESH_BITS : BLINK_BIT + 1;
  localparam int SUM_W = PEND_BITS + 6;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'({PEND_BITS{1'b1}});

  state_t               state, state_nxt;
  logic [15:0]          score, score_nxt;
  logic [15:0]          high, high_nxt;
  logic                 new_high, new_high_nxt;
  logic [PEND_BITS-1:0] pending, pending_nxt, pend_sat;
  logic                 alive_q;
  logic [MONSTERS-1:0]  pulse_q, hit;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           an_r, an_nxt, digit;
  logic [7:0]           seg_r, seg_dec;
  logic [1:0]           k;
  logic [15:0]          src;
  logic                 rise, fall, drain, blank;
  logic [5:0]           hits;
  logic [SUM_W-1:0]     pend_sum;

  assign rise  = bus.alive & ~alive_q;
  assign fall  = ~bus.alive & alive_q;
  assign hit   = bus.score_pulse & ~pulse_q;
  assign hits  = popcount(32'(hit));
  assign drain = (pending != '0);

  // Sum is wide enough that a full pending count plus every bit rising cannot overflow before the clamp.
  assign pend_sum = SUM_W'(pending) + SUM_W'(hits) - SUM_W'(drain);
  assign pend_sat = (pend_sum > PEND_MAX) ? '1 : pend_sum[PEND_BITS-1:0];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_nxt    = state;
    score_nxt    = score;
    high_nxt     = high;
    new_high_nxt = new_high;
    pending_nxt  = pending;
    case (state)
      IDLE, OVER: begin
        if (rise) begin
          score_nxt    = '0;
          pending_nxt  = '0;
          new_high_nxt = 1'b0;
          state_nxt    = PLAYING;
        end
      end
      PLAYING: begin
        pending_nxt = pend_sat;
        if (drain) score_nxt = bcd_inc(score);
        if (fall)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rise) begin
          // A new game cuts the drain short; the partial score still competes for the record.
          if (score > high) high_nxt = score;
          score_nxt    = '0;
          pending_nxt  = '0;
          new_high_nxt = 1'b0;
          state_nxt    = PLAYING;
        end else if (!drain) begin
          if (score > high) begin
            high_nxt     = score;
            new_high_nxt = 1'b1;
          end
          state_nxt = OVER;
        end else begin
          pending_nxt = pending - 1'b1;
          score_nxt   = bcd_inc(score);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign k      = cnt[REFRESH_BITS-1 -: 2];
  assign src    = (state == IDLE) ? high : score;
  assign digit  = src[{k, 2'b00} +: 4];
  assign blank  = (state == OVER) && new_high && cnt[BLINK_BIT];
  assign an_nxt = blank ? 4'b1111 : ~(4'b0001 << k);

  seg7_decode u_seg7 (
    .digit (digit),
    .seg   (seg_dec)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      score    <= '0;
      high     <= '0;
      new_high <= 1'b0;
      pending  <= '0;
      alive_q  <= 1'b0;
      pulse_q  <= '0;
      cnt      <= '0;
      an_r     <= 4'b1111;
      seg_r    <= SEG_OFF;
    end else begin
      state    <= state_nxt;
      score    <= score_nxt;
      high     <= high_nxt;
      new_high <= new_high_nxt;
      pending  <= pending_nxt;
      alive_q  <= bus.alive;
      pulse_q  <= bus.score_pulse;
      cnt      <= cnt + CNT_W'(1);
      an_r     <= an_nxt;
      seg_r    <= seg_dec;
    end
  end

  assign bus.score_bcd = score;
  assign bus.high_bcd  = high;
  assign bus.new_high  = new_high;
  assign bus.an        = an_r;
  assign bus.seg       = seg_r;

endmodule
